// File: rtl/prefix_mp_seq_pkg.sv
// Shared definitions for the multi-precision prefix-adder sequencer:
// FSM state encoding and the byte-slice width.
package prefix_mp_seq_pkg;

  localparam int SLICE = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/prefix_mp_seq_prefixAdd.sv
// 8-bit Kogge-Stone prefix adder with carry-in; sum only, no carry out.
// The sequencer reconstructs the byte carry-out from the operand and sum MSBs.
module prefixAdd (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] S
);

  logic [7:0] w_g0;
  logic [7:0] w_p0;
  logic [6:0] w_g1;
  logic [6:0] w_p1;
  logic [6:0] w_g2;
  logic [6:0] w_p2;
  logic [6:0] w_g3;
  logic [6:0] w_p3;
  logic [7:0] w_c;

  assign w_g0 = a & b;
  assign w_p0 = a ^ b;

  // Three prefix levels (span 1, 2, 4) cover carries into bits 1..7.
  for (genvar i = 0; i < 7; i++) begin : gLevels
    if (i >= 1) begin : gL1
      assign w_g1[i] = w_g0[i] | (w_p0[i] & w_g0[i-1]);
      assign w_p1[i] = w_p0[i] & w_p0[i-1];
    end else begin : gL1Pass
      assign w_g1[i] = w_g0[i];
      assign w_p1[i] = w_p0[i];
    end
    if (i >= 2) begin : gL2
      assign w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[i-2]);
      assign w_p2[i] = w_p1[i] & w_p1[i-2];
    end else begin : gL2Pass
      assign w_g2[i] = w_g1[i];
      assign w_p2[i] = w_p1[i];
    end
    if (i >= 4) begin : gL3
      assign w_g3[i] = w_g2[i] | (w_p2[i] & w_g2[i-4]);
      assign w_p3[i] = w_p2[i] & w_p2[i-4];
    end else begin : gL3Pass
      assign w_g3[i] = w_g2[i];
      assign w_p3[i] = w_p2[i];
    end
  end

  assign w_c = {w_g3 | (w_p3 & {7{cin}}), cin};
  assign S   = w_p0 ^ w_c;

endmodule

// File: rtl/prefix_mp_seq.sv
// Multi-precision add/subtract: streams W-bit operands one byte per clock
// through a single prefixAdd, LSB first, chaining the carry in a register.
module prefix_mp_seq
  import prefix_mp_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sub,
  input  logic [SLICE*NBYTES-1:0]   a,
  input  logic [SLICE*NBYTES-1:0]   b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [SLICE*NBYTES-1:0]   sum,
  output logic                      cout,
  output logic                      ovf
);

  localparam int W  = SLICE * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_opA;
  logic [W-1:0]    r_opB;
  logic            r_carry;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic [SLICE-1:0] w_aByte;
  logic [SLICE-1:0] w_bByte;
  logic [SLICE-1:0] w_sByte;
  logic             w_c7;
  logic             w_c8;

  assign w_aByte = r_opA[SLICE*r_idx +: SLICE];
  assign w_bByte = r_opB[SLICE*r_idx +: SLICE];

  prefixAdd u_prefixAdd (
    .a   (w_aByte),
    .b   (w_bByte),
    .cin (r_carry),
    .S   (w_sByte)
  );

  // The adder has no carry output: recover the MSB carry-in from the sum bit,
  // then the carry-out as generate-or-(propagate-and-carry-in).
  assign w_c7 = w_aByte[SLICE-1] ^ w_bByte[SLICE-1] ^ w_sByte[SLICE-1];
  assign w_c8 = (w_aByte[SLICE-1] & w_bByte[SLICE-1]) |
                ((w_aByte[SLICE-1] ^ w_bByte[SLICE-1]) & ~w_sByte[SLICE-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_opA   <= '0;
      r_opB   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_opA   <= a;
            r_opB   <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum[SLICE*r_idx +: SLICE] <= w_sByte;
          r_carry <= w_c8;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_c8;
            r_ovf   <= w_c7 ^ w_c8;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_prefix_mp_seq.sv
// Directed bench for prefix_mp_seq (NBYTES=4): hand-computed vectors for add,
// subtract, overflow, busy-start rejection, held start and async reset abort.
module tb_prefix_mp_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int vectorCount = 0;
  int missCount   = 0;

  prefix_mp_seq #(.NBYTES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Pulses start for one cycle and waits (bounded) for done; latency counts
  // negedges after the accepting edge, so done is expected at 5.
  task automatic applyStimulus(input logic s, input logic [31:0] x, input logic [31:0] y,
                               input logic c, output int lat, output int busyCnt);
    @(negedge clk);
    sub = s; a = x; b = y; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busyCnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) busyCnt++;
    end
  endtask

  task automatic runCase(input string tag, input logic s, input logic [31:0] x,
                         input logic [31:0] y, input logic c, input logic [31:0] expSum,
                         input logic expCout, input logic expOvf);
    int lat, busyCnt;
    applyStimulus(s, x, y, c, lat, busyCnt);
    checkOutput({tag, "_lat"}, 32'(lat), 32'd5);
    checkOutput({tag, "_sum"}, sum, expSum);
    checkOutput({tag, "_cout"}, {31'd0, cout}, {31'd0, expCout});
    checkOutput({tag, "_ovf"}, {31'd0, ovf}, {31'd0, expOvf});
  endtask

  initial begin
    int lat, busyCnt, doneSeen, firstDone, secondDone;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(negedge clk);
    checkOutput("rst_sum", sum, 32'h0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First op also checks busy duration and that busy drops after DONE.
    applyStimulus(1'b0, 32'h0, 32'h41, 1'b0, lat, busyCnt);
    checkOutput("basic_lat", 32'(lat), 32'd5);
    checkOutput("basic_busy", 32'(busyCnt), 32'd5);
    checkOutput("basic_sum", sum, 32'h41);
    checkOutput("basic_flags", {30'd0, cout, ovf}, 32'd0);
    @(negedge clk);
    checkOutput("basic_idle", {30'd0, busy, done}, 32'd0);
    checkOutput("basic_hold", sum, 32'h41);

    runCase("ripple_all", 1'b0, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
    runCase("ripple_b0", 1'b0, 32'h000000FF, 32'h1, 1'b0, 32'h100, 1'b0, 1'b0);
    runCase("ovf_pos", 1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1);
    runCase("ovf_neg", 1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h0, 1'b1, 1'b1);
    runCase("sub_pos", 1'b1, 32'h64, 32'h18, 1'b0, 32'h4C, 1'b1, 1'b0);
    runCase("sub_neg", 1'b1, 32'h14, 32'hB2, 1'b0, 32'hFFFFFF62, 1'b0, 1'b0);
    runCase("sub_cin1", 1'b1, 32'h64, 32'h18, 1'b1, 32'h4C, 1'b1, 1'b0);
    runCase("sub_zero", 1'b1, 32'h12345678, 32'h0, 1'b0, 32'h12345678, 1'b1, 1'b0);
    runCase("sub_ovf", 1'b1, 32'h80000000, 32'h1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
    runCase("add_cin", 1'b0, 32'hB1, 32'h36, 1'b1, 32'hE8, 1'b0, 1'b0);

    // Starts during RUN and during DONE must be dropped.
    @(negedge clk);
    sub = 1'b0; cin = 1'b0; a = 32'h10; b = 32'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    @(negedge clk);
    lat++;
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("busy_lat", 32'(lat), 32'd5);
    a = 32'h5; b = 32'h5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_sum", sum, 32'h30);
    checkOutput("busy_drop_done", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    checkOutput("busy_not_queued", {30'd0, busy, done}, 32'd0);
    runCase("after_busy", 1'b0, 32'h5, 32'h5, 1'b0, 32'hA, 1'b0, 1'b0);

    // start held high: operations repeat every NBYTES+2 cycles.
    @(negedge clk);
    a = 32'h1; b = 32'h2; start = 1'b1;
    firstDone = 0; secondDone = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (done && firstDone == 0) firstDone = k;
      else if (done && secondDone == 0) secondDone = k;
    end
    start = 1'b0;
    checkOutput("held_first", 32'(firstDone), 32'd5);
    checkOutput("held_period", 32'(secondDone - firstDone), 32'd6);
    checkOutput("held_sum", sum, 32'h3);
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    checkOutput("held_drain", {31'd0, busy}, 32'd0);

    // Async reset in the second RUN cycle aborts without a done pulse.
    @(negedge clk);
    a = 32'h11111111; b = 32'h22222222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_sum", sum, 32'h0);
    checkOutput("abort_state", {29'd0, busy, done, cout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || busy) doneSeen++;
    end
    checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
    runCase("after_rst", 1'b0, 32'h64, 32'h32, 1'b0, 32'h96, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/prefix_mp_seq.md
Name: prefix_mp_seq

Overview:
Multi-precision add/subtract sequencer built around the existing 8-bit prefixAdd datapath. It takes W = 8*NBYTES-bit operands on a start pulse and feeds them through one prefixAdd instance, one byte per clock, LSB byte first. It chains the carry between bytes in a register and presents the full result with carry-out and signed overflow on a one-cycle done pulse. It is the sequencing layer that lets the team's 8-bit prefix adder serve wide arithmetic without replicating it.

Parameters:
NBYTES, 4, number of 8-bit slices per operand (>=2); W = 8*NBYTES.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; accepted only in IDLE
sub  input  1  1 = a - b (b inverted, carry-in forced 1); 0 = a + b + cin
a  input  W  operand A, sampled on accepted start
b  input  W  operand B, sampled on accepted start
cin  input  1  carry-in for add mode, sampled on accepted start; ignored when sub=1
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, result valid
sum  output  W  result register
cout  output  1  carry out of MSB (sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, cout, ovf = 0; sum = 0; idx = 0; carry reg = 0; operand regs = 0. No done pulse is issued for an aborted operation.
- FSM states IDLE, RUN, DONE; busy = (state != IDLE); done = (state == DONE).
- IDLE:
  - on start=1: latch opA=a, opB = sub ? ~b : b, carry = sub ? 1 : cin; clear sum, cout, ovf; idx=0; go to RUN.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - drive prefixAdd with a=opA[8*idx+:8], b=opB[8*idx+:8], cin=carry.
  - register S into sum[8*idx+:8].
  - carry <= c8, where c8 = (a7&b7) | ((a7^b7)&~S7). prefixAdd has no carry output, so c8 is derived from the byte MSBs.
  - if idx==NBYTES-1: cout <= c8; ovf <= (a7^b7^S7)^c8, i.e. carry into MSB xor carry out; go to DONE. Otherwise idx <= idx+1.
- DONE: one cycle, done=1, then go to IDLE unconditionally.
- Latency: start accepted at edge T, done high during cycle T+NBYTES+1. Throughput is one operation per NBYTES+2 cycles.
- start while busy (RUN or DONE) is ignored and not queued. A start held high is re-accepted on the first IDLE cycle.
- sum, cout and ovf hold their values after DONE until the next accepted start or reset.
- The partial sum in sum is visible during RUN and is not guaranteed meaningful until done.
- Wrap-around: results are modulo 2^W, with cout and ovf reporting the excess. Subtract with b=0 gives sum=a, cout=1.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the SLICE=8 constant.
- Single sub-module: prefixAdd, instantiated once as the byte-slice adder.
- The carry derivation and slice muxing stay in prefix_mp_seq.

Test Plan:
- NBYTES=4, a=0x00000000, b=0x00000041, cin=0, sub=0, start pulse -> done at cycle 5 after start; sum=0x00000041, cout=0, ovf=0; busy high for exactly 5 cycles.
- Ripple across all slices: a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, cout=1, ovf=0. Also a=0x000000FF, b=0x00000001 -> sum=0x00000100, cout=0.
- Signed overflow and subtract:
  - a=0x7FFFFFFF + b=1 -> sum=0x80000000, ovf=1, cout=0.
  - sub=1, a=0x00000064, b=0x00000018 -> sum=0x0000004C, cout=1, ovf=0.
  - sub=1, a=0x14, b=0xB2 -> sum=0xFFFFFF62, cout=0.
- Start while busy: second start with different operands asserted in RUN and in the DONE cycle -> ignored; result matches the first operands; next start accepted in IDLE. start held high -> back-to-back ops every 6 cycles.
- rst asserted in the second RUN cycle -> outputs and sum go to 0 immediately (async), state IDLE, no done pulse. A new op after reset release completes correctly (0x64 + 0x32 = 0x96).
- cin=1 in add mode: 0x000000B1 + 0x00000036 + 1 -> sum=0x000000E8. cin=1 with sub=1 gives the same result as cin=0.
